// File: rtl/load_store_unit.sv
// load_store_unit
//   Connects the MEM pipeline stage to a word-wide, big-endian data memory.
//   Accepts one byte/halfword/word load or store at a time. Loads and word
//   stores take a single memory access. Byte/halfword stores are done as a
//   read-modify-write, because the memory writes only whole words.
//
//   Optional feature macro: LSU_ALIGN_CHECK_EN
//     defined   : a misaligned halfword/word request is answered with
//                 resp_error=1 and causes no memory access.
//     undefined : misaligned low address bits are masked; resp_error is 0.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 halfword, 1x word
//   req_signed          sign-extend loaded data
//   req_addr, req_wdata byte address, right-justified store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores/errors)
//   resp_error          misaligned request rejected
//   mem_address         word-aligned memory address (registered)
//   mem_writeData       memory write word (registered)
//   mem_read/mem_write  strobes decoded from the registered state
//   mem_readData        memory read word, valid while mem_read is high
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_readData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_RD,
        S_ST_WR,
        S_RMW_RD,
        S_RMW_WR
    } state_t;

    state_t             r_state;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [1:0]         r_offset;
    logic [31:0]        r_wdata;
    logic               r_resp_valid;
    logic [31:0]        r_resp_rdata;
    logic [ADDR_W-1:0]  r_mem_address;
    logic [31:0]        r_mem_writeData;

    logic               w_is_half;
    logic               w_is_word;
    logic               w_misaligned;
    logic [1:0]         w_offset;
    logic [4:0]         w_shamt;
    logic [31:0]        w_shifted;
    logic [31:0]        w_load_data;
    logic [31:0]        w_lane_mask;
    logic [31:0]        w_lane_data;
    logic [31:0]        w_merged;

    assign w_is_half = (req_size == 2'b01);
    assign w_is_word = req_size[1];

`ifdef LSU_ALIGN_CHECK_EN
    logic r_resp_error;
    assign w_misaligned = (w_is_half && req_addr[0]) ||
                          (w_is_word && (req_addr[1:0] != 2'b00));
    assign resp_error   = r_resp_error;
`else
    assign w_misaligned = 1'b0;
    assign resp_error   = 1'b0;
`endif

    // Byte offset inside the word as it will be used for lane selection;
    // low bits that a halfword/word cannot address are dropped here.
    always_comb begin
        if (w_is_word)      w_offset = 2'b00;
        else if (w_is_half) w_offset = {req_addr[1], 1'b0};
        else                w_offset = req_addr[1:0];
    end

    // Right-shift that brings the addressed big-endian lane down to bit 0.
    // Byte at offset o lives at bit 8*(3-o); 3-o is simply ~o for 2 bits.
    always_comb begin
        case (r_size)
            2'b00:   w_shamt = {~r_offset, 3'b000};
            2'b01:   w_shamt = {~r_offset[1], 4'b0000};
            default: w_shamt = 5'd0;
        endcase
    end

    assign w_shifted = mem_readData >> w_shamt;

    always_comb begin
        case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // Lane mask and positioned store data for the read-modify-write merge.
    always_comb begin
        case (r_size)
            2'b00: begin
                w_lane_mask = 32'h0000_00FF << w_shamt;
                w_lane_data = {24'h0, r_wdata[7:0]} << w_shamt;
            end
            2'b01: begin
                w_lane_mask = 32'h0000_FFFF << w_shamt;
                w_lane_data = {16'h0, r_wdata[15:0]} << w_shamt;
            end
            default: begin
                w_lane_mask = 32'hFFFF_FFFF;
                w_lane_data = r_wdata;
            end
        endcase
    end

    assign w_merged = (mem_readData & ~w_lane_mask) | (w_lane_data & w_lane_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_size          <= 2'b00;
            r_signed        <= 1'b0;
            r_offset        <= 2'b00;
            r_wdata         <= 32'h0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'h0;
            r_mem_address   <= '0;
            r_mem_writeData <= 32'h0;
`ifdef LSU_ALIGN_CHECK_EN
            r_resp_error    <= 1'b0;
`endif
        end else begin
            // Response outputs are single-cycle pulses.
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
`ifdef LSU_ALIGN_CHECK_EN
            r_resp_error <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_offset <= w_offset;
                        r_wdata  <= req_wdata;
                        if (w_misaligned) begin
                            // Rejected without touching memory.
                            r_resp_valid <= 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
                            r_resp_error <= 1'b1;
`endif
                        end else begin
                            r_mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (!req_write) begin
                                r_state <= S_LD_RD;
                            end else if (w_is_word) begin
                                r_mem_writeData <= req_wdata;
                                r_state         <= S_ST_WR;
                            end else begin
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LD_RD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                    r_state      <= S_IDLE;
                end
                S_ST_WR: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_RMW_RD: begin
                    r_mem_writeData <= w_merged;
                    r_state         <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign mem_read      = (r_state == S_LD_RD) || (r_state == S_RMW_RD);
    assign mem_write     = (r_state == S_ST_WR) || (r_state == S_RMW_WR);
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign mem_address   = r_mem_address;
    assign mem_writeData = r_mem_writeData;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writeData;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_readData;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_writeData(mem_writeData),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_readData (mem_readData)
    );

    // ---------------- counters and bookkeeping ----------------
    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int rd_cnt     = 0;
    int wr_cnt     = 0;
    int exp_rd     = 0;
    int exp_wr     = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err   = 1'b0;
    int          resp_cycles[$];
    logic        load_mem;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t expq[$];

    // Reference memory: plain byte array, big-endian (lowest address = MSB).
    logic [7:0]  ref_mem [0:1023];
    // Word memory seen by the DUT.
    logic [31:0] mem_arr [0:255];

    assign mem_readData = mem_read ? mem_arr[mem_address[9:2]] : 32'hA5A5_A5A5;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_mem) begin
            for (int k = 0; k < 256; k++)
                mem_arr[k] <= {ref_mem[4*k], ref_mem[4*k+1], ref_mem[4*k+2], ref_mem[4*k+3]};
        end else if (mem_write) begin
            mem_arr[mem_address[9:2]] <= mem_writeData;
        end
        if (!reset) begin
            if (mem_read) rd_cnt <= rd_cnt + 1;
            if (mem_write) begin
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= mem_address;
                last_wdata <= mem_writeData;
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                chk("resp_valid", {31'b0, resp_valid}, 32'd1);
                chk("resp_rdata", resp_rdata, expq[0].rdata);
                chk("resp_error", {31'b0, resp_error}, {31'b0, expq[0].err});
                if (resp_valid) begin
                    last_rdata = resp_rdata;
                    last_err   = resp_error;
                    resp_cycles.push_back(cyc);
                end
                void'(expq.pop_front());
            end else begin
                chk("resp_quiet", {31'b0, resp_valid}, 32'd0);
            end
            if (mem_read || mem_write)
                chk("mem_align", {30'b0, mem_address[1:0]}, 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a[9:0]]       = v[31:24];
        ref_mem[a[9:0] + 10'd1] = v[23:16];
        ref_mem[a[9:0] + 10'd2] = v[15:8];
        ref_mem[a[9:0] + 10'd3] = v[7:0];
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
        chk("rst_mem_address", mem_address,        32'd0);
        chk("rst_mem_wdata",  mem_writeData,       32'd0);
        chk("rst_mem_read",   {31'b0, mem_read},   32'd0);
        chk("rst_mem_write",  {31'b0, mem_write},  32'd0);
    endtask

    // Drives a request (called on a negedge), waits for acceptance, records
    // the model's expectation, and returns on the negedge after acceptance
    // with req_valid still high.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input bit abort);
        int          waitc;
        int          acc;
        int          lat;
        exp_t        e;
        logic [9:0]  ea;
        logic        err;
        logic [31:0] val;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        // Effective byte address and alignment decision.
        if (sz == 2'b00)      ea = addr[9:0];
        else if (sz == 2'b01) ea = {addr[9:1], 1'b0};
        else                  ea = {addr[9:2], 2'b00};
`ifdef LSU_ALIGN_CHECK_EN
        err = (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
`else
        err = 1'b0;
`endif
        val = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            lat = 2;
            if (sz == 2'b00)
                val = sg ? {{24{ref_mem[ea][7]}}, ref_mem[ea]} : {24'h0, ref_mem[ea]};
            else if (sz == 2'b01)
                val = sg ? {{16{ref_mem[ea][7]}}, ref_mem[ea], ref_mem[ea + 10'd1]}
                         : {16'h0, ref_mem[ea], ref_mem[ea + 10'd1]};
            else
                val = {ref_mem[ea], ref_mem[ea + 10'd1], ref_mem[ea + 10'd2], ref_mem[ea + 10'd3]};
        end else if (sz[1]) begin
            lat = 2;
        end else begin
            lat = 3;
        end
        if (!abort) begin
            e.cyc   = acc + lat - 1;
            e.rdata = val;
            e.err   = err;
            expq.push_back(e);
            if (!err) begin
                if (!wr) exp_rd++;
                else if (sz[1]) exp_wr++;
                else begin exp_rd++; exp_wr++; end
                if (wr) begin
                    if (sz == 2'b00) ref_mem[ea] = wd[7:0];
                    else if (sz == 2'b01) begin
                        ref_mem[ea]         = wd[15:8];
                        ref_mem[ea + 10'd1] = wd[7:0];
                    end else begin
                        ref_mem[ea]         = wd[31:24];
                        ref_mem[ea + 10'd1] = wd[23:16];
                        ref_mem[ea + 10'd2] = wd[15:8];
                        ref_mem[ea + 10'd3] = wd[7:0];
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    // Directed load table for the word 0x80FF7F01 at 0x20.
    logic [31:0] ld_addr [0:7] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h20, 32'h22, 32'h22, 32'h20};
    logic [1:0]  ld_size [0:7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    logic        ld_sgn  [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ld_exp  [0:7] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_007F, 32'h0000_0001,
                                   32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_7F01, 32'h0000_80FF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd0;
        int wr0;
        int n;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int k = 0; k < 1024; k++) ref_mem[k] = 8'h00;
        set_word(32'h04, 32'h0123_4567);
        set_word(32'h14, 32'h5566_7788);
        set_word(32'h20, 32'h80FF_7F01);
        set_word(32'h30, 32'h1122_3344);
        set_word(32'h40, 32'hCAFE_F00D);
        load_mem = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_mem = 1'b0;
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);

        // Word store then word load.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        idle(3);
        chk("sw_addr", last_waddr, 32'h10);
        chk("sw_data", last_wdata, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        idle(3);
        chk("lw_data", last_rdata, 32'hDEAD_BEEF);

        // Byte/halfword loads, signed and unsigned.
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, ld_size[i], ld_sgn[i], ld_addr[i], 32'h0, 1'b0);
            idle(3);
            chk("subword_load", last_rdata, ld_exp[i]);
        end

        // Halfword store via read-modify-write.
        rd0 = rd_cnt;
        issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_AABB, 1'b0);
        idle(3);
        chk("sh_reads", rd_cnt - rd0, 32'd1);
        chk("sh_addr", last_waddr, 32'h30);
        chk("sh_data", last_wdata, 32'h1122_AABB);
        issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h1234_5699, 1'b0);
        idle(3);
        chk("sb_data", last_wdata, 32'h1199_AABB);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);
        idle(3);
        chk("lw_after_rmw", last_rdata, 32'h1199_AABB);

        // Misaligned word load.
        rd0 = rd_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 1'b0);
        idle(3);
`ifdef LSU_ALIGN_CHECK_EN
        chk("mis_err", {31'b0, last_err}, 32'd1);
        chk("mis_rdata", last_rdata, 32'h0);
        chk("mis_reads", rd_cnt - rd0, 32'd0);
`else
        chk("mis_rdata", last_rdata, 32'h0123_4567);
        chk("mis_reads", rd_cnt - rd0, 32'd1);
`endif

        // Back-to-back loads with req_valid held high.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);
        idle(3);
        n = resp_cycles.size();
        if (n >= 2) chk("b2b_gap", resp_cycles[n-1] - resp_cycles[n-2], 32'd2);
        else        chk("b2b_resp_count", n, 32'd2);
        chk("b2b_second", last_rdata, 32'h5566_7788);

        // Reset while the byte store is in its read phase.
        wr0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h0000_0077, 1'b1);
        chk("rmw_rd_phase", {31'b0, mem_read}, 32'd1);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        chk("rst_no_write", wr_cnt - wr0, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        idle(3);
        chk("rst_word_kept", last_rdata, 32'hCAFE_F00D);

        // Byte store to the last lane, then signed read of it.
        issue(1'b1, 2'b00, 1'b0, 32'h43, 32'h0000_00EE, 1'b0);
        idle(3);
        chk("sb_lane3", last_wdata, 32'hCAFE_F0EE);
        issue(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1'b0);
        idle(3);
        chk("lb_lane3", last_rdata, 32'hFFFF_FFEE);

        // Final accounting against the model.
        idle(4);
        chk("pending_resp", expq.size(), 32'd0);
        chk("read_count", rd_cnt, exp_rd);
        chk("write_count", wr_cnt, exp_wr);
        for (int k = 0; k < 256; k++)
            chk("mem_image", mem_arr[k],
                {ref_mem[4*k], ref_mem[4*k+1], ref_mem[4*k+2], ref_mem[4*k+3]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
